// File: rtl/ranger_pkg.sv
// ranger_pkg: shared ranger constants, move codes, state encoding and position field helpers.
package ranger_pkg;
  localparam logic [9:0] UP_BOUND    = 10'd31;
  localparam logic [9:0] DOWN_BOUND  = 10'd510;
  localparam logic [9:0] LEFT_BOUND  = 10'd144;
  localparam logic [9:0] RIGHT_BOUND = 10'd783;
  localparam logic [3:0] MOVE_UP    = 4'b1000;
  localparam logic [3:0] MOVE_DOWN  = 4'b0100;
  localparam logic [3:0] MOVE_LEFT  = 4'b0010;
  localparam logic [3:0] MOVE_RIGHT = 4'b0001;
  localparam logic [3:0] MOVE_NONE  = 4'b0000;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PAT_R  = 3'd1,
    ST_PAT_L  = 3'd2,
    ST_CHASE  = 3'd3,
    ST_RETURN = 3'd4
  } state_t;
  function automatic logic [9:0] pos_h(input logic [19:0] p);
    return p[19:10];
  endfunction
  function automatic logic [9:0] pos_v(input logic [19:0] p);
    return p[9:0];
  endfunction
endpackage

// File: rtl/step_ticker.sv
// step_ticker: one-cycle tick every STEP_DIV enabled cycles; disabling parks the count at 0.
module step_ticker #(
  parameter logic [19:0] STEP_DIV = 20'd416667
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_tick
);
  logic [19:0] r_cnt;
  assign o_tick = i_enable && (r_cnt == STEP_DIV - 20'd1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (!i_enable || o_tick) ? '0 : r_cnt + 20'd1;
endmodule

// File: rtl/ranger_move_ctrl.sv
// ranger_move_ctrl: patrol/chase/return FSM issuing one-cycle one-hot move pulses per step tick.
module ranger_move_ctrl
  import ranger_pkg::*;
#(
  parameter logic [19:0] STEP_DIV     = 20'd416667,
  parameter logic [9:0]  CHASE_RADIUS = 10'd64,
  parameter logic [9:0]  PATROL_SPAN  = 10'd96
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [19:0] i_position,
  input  logic [19:0] i_player_pos,
  input  logic [19:0] i_home_pos,
  output logic [3:0]  o_move,
  output logic [2:0]  o_mode
);
  logic              w_tick;
  state_t            r_state, w_next;
  logic [3:0]        r_move, w_raw, w_cmd;
  logic [9:0]        w_h, w_v, w_ph, w_pv, w_hh, w_hv;
  logic signed [10:0] w_dx, w_dy;
  logic [10:0]       w_adx, w_ady, w_d;
  logic signed [11:0] w_hs, w_pat_hi, w_pat_lo;
  logic              w_near, w_far, w_home, w_blocked;

  function automatic logic [3:0] step_toward(input logic [9:0] h, v, th, tv);
    logic signed [10:0] ex, ey;
    logic [10:0] ax, ay;
    ex = $signed({1'b0, th}) - $signed({1'b0, h});
    ey = $signed({1'b0, tv}) - $signed({1'b0, v});
    ax = ex[10] ? -ex : ex;
    ay = ey[10] ? -ey : ey;
    return (ax == '0 && ay == '0) ? MOVE_NONE :
           (ax >= ay) ? (ex[10] ? MOVE_LEFT : MOVE_RIGHT) :
                        (ey[10] ? MOVE_UP : MOVE_DOWN);
  endfunction

  step_ticker #(.STEP_DIV(STEP_DIV)) u_ticker (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .o_tick(w_tick)
  );

  assign w_h  = pos_h(i_position);
  assign w_v  = pos_v(i_position);
  assign w_ph = pos_h(i_player_pos);
  assign w_pv = pos_v(i_player_pos);
  assign w_hh = pos_h(i_home_pos);
  assign w_hv = pos_v(i_home_pos);
  assign w_dx  = $signed({1'b0, w_ph}) - $signed({1'b0, w_h});
  assign w_dy  = $signed({1'b0, w_pv}) - $signed({1'b0, w_v});
  assign w_adx = w_dx[10] ? -w_dx : w_dx;
  assign w_ady = w_dy[10] ? -w_dy : w_dy;
  assign w_d   = (w_adx >= w_ady) ? w_adx : w_ady;
  assign w_near = w_d < {1'b0, CHASE_RADIUS};
  assign w_far  = w_d >= {CHASE_RADIUS, 1'b0};
  assign w_home = (w_h == w_hh) && (w_v == w_hv);
  // Signed 12-bit patrol limits so home near either screen edge never wraps.
  assign w_hs     = $signed({2'b00, w_h});
  assign w_pat_hi = $signed({2'b00, w_hh}) + $signed({2'b00, PATROL_SPAN});
  assign w_pat_lo = $signed({2'b00, w_hh}) - $signed({2'b00, PATROL_SPAN});

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_move  <= MOVE_NONE;
    end else begin
      if (w_tick) r_state <= w_next;
      r_move <= w_tick ? w_cmd : MOVE_NONE;
    end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_PAT_R;
      ST_PAT_R:  w_next = w_near ? ST_CHASE : (w_hs >= w_pat_hi || w_h >= RIGHT_BOUND) ? ST_PAT_L : ST_PAT_R;
      ST_PAT_L:  w_next = w_near ? ST_CHASE : (w_hs <= w_pat_lo || w_h <= LEFT_BOUND) ? ST_PAT_R : ST_PAT_L;
      ST_CHASE:  w_next = w_far ? ST_RETURN : ST_CHASE;
      ST_RETURN: w_next = w_near ? ST_CHASE : w_home ? ST_PAT_R : ST_RETURN;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Bound suppression only masks the pulse; the state decision above ignores it.
  always_comb begin
    w_raw = MOVE_NONE;
    case (r_state)
      ST_PAT_R:  w_raw = MOVE_RIGHT;
      ST_PAT_L:  w_raw = MOVE_LEFT;
      ST_CHASE:  w_raw = step_toward(w_h, w_v, w_ph, w_pv);
      ST_RETURN: w_raw = step_toward(w_h, w_v, w_hh, w_hv);
      default:   w_raw = MOVE_NONE;
    endcase
    w_blocked = (w_raw == MOVE_UP && w_v <= UP_BOUND) || (w_raw == MOVE_DOWN && w_v >= DOWN_BOUND) ||
                (w_raw == MOVE_LEFT && w_h <= LEFT_BOUND) || (w_raw == MOVE_RIGHT && w_h >= RIGHT_BOUND);
    w_cmd = w_blocked ? MOVE_NONE : w_raw;
  end

  assign o_move = r_move;
  assign o_mode = r_state;
endmodule

// File: tb/tb_ranger_move_ctrl.sv
// tb_ranger_move_ctrl: randomized scoreboard bench against an integer reference model of the ranger.
module tb_ranger_move_ctrl;
  localparam int SD = 4, R = 64, SPAN = 96;
  localparam int IDLE = 0, PAT_R = 1, PAT_L = 2, CHASE = 3, RET = 4;
  logic clk = 0, rst_n = 0, en = 0;
  logic [19:0] pos, ply, home;
  logic [3:0] move;
  logic [2:0] mode;
  int tests = 0, fails = 0;
  int m_cnt = 0, m_st = IDLE;
  bit due = 0, follow = 0;
  logic [3:0] m_mv = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  ranger_move_ctrl #(.STEP_DIV(20'd4), .CHASE_RADIUS(10'd64), .PATROL_SPAN(10'd96)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_position(pos), .i_player_pos(ply),
    .i_home_pos(home), .o_move(move), .o_mode(mode)
  );

  function automatic int iabs(int x);
    return x < 0 ? -x : x;
  endfunction
  function automatic logic [19:0] pk(int h, int v);
    return {10'(h), 10'(v)};
  endfunction
  function automatic int clamp(int x);
    return x < 0 ? 0 : x > 1023 ? 1023 : x;
  endfunction
  function automatic logic [3:0] toward(int h, int v, int th, int tv);
    int ex, ey;
    ex = th - h;
    ey = tv - v;
    if (ex == 0 && ey == 0) return 4'b0000;
    if (iabs(ex) >= iabs(ey)) return ex > 0 ? 4'b0001 : 4'b0010;
    return ey > 0 ? 4'b0100 : 4'b1000;
  endfunction
  function automatic logic [3:0] clip(logic [3:0] mv, int h, int v);
    if ((mv == 4'b1000 && v <= 31) || (mv == 4'b0100 && v >= 510) ||
        (mv == 4'b0010 && h <= 144) || (mv == 4'b0001 && h >= 783)) return 4'b0000;
    return mv;
  endfunction
  function automatic logic [19:0] apply(logic [19:0] p, logic [3:0] mv);
    int h, v;
    h = p[19:10];
    v = p[9:0];
    h = h + (mv == 4'b0001 ? 1 : 0) - (mv == 4'b0010 ? 1 : 0);
    v = v + (mv == 4'b0100 ? 1 : 0) - (mv == 4'b1000 ? 1 : 0);
    return pk(h, v);
  endfunction

  task automatic chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: decides each step from the behavioural rules on whole integers.
  always @(posedge clk) begin
    int h, v, hh, hv, ph, pv, d, ns;
    logic [3:0] mv;
    if (!rst_n) begin
      m_cnt = 0;
      m_st = IDLE;
      due = 0;
    end else begin
      due = en && m_cnt == SD - 1;
      m_cnt = (!en || due) ? 0 : m_cnt + 1;
      if (due) begin
        h = pos[19:10]; v = pos[9:0];
        hh = home[19:10]; hv = home[9:0];
        ph = ply[19:10]; pv = ply[9:0];
        d = iabs(ph - h) > iabs(pv - v) ? iabs(ph - h) : iabs(pv - v);
        mv = 4'b0000;
        ns = m_st;
        if (m_st == IDLE) ns = PAT_R;
        else if (m_st == PAT_R) begin
          mv = 4'b0001;
          ns = d < R ? CHASE : (h >= hh + SPAN || h >= 783) ? PAT_L : PAT_R;
        end else if (m_st == PAT_L) begin
          mv = 4'b0010;
          ns = d < R ? CHASE : (h <= hh - SPAN || h <= 144) ? PAT_R : PAT_L;
        end else if (m_st == CHASE) begin
          mv = toward(h, v, ph, pv);
          ns = d >= 2 * R ? RET : CHASE;
        end else begin
          mv = toward(h, v, hh, hv);
          ns = d < R ? CHASE : (h == hh && v == hv) ? PAT_R : RET;
        end
        m_mv = clip(mv, h, v);
        m_st = ns;
        exp_q.push_back(m_mv);
      end
    end
  end

  // Monitor: every cycle the pulse must match the scoreboard or be absent.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_move", move, 0);
      chk("rst_mode", mode, IDLE);
      exp_q.delete();
    end else begin
      if (due) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL q_empty: got pulse slot with no expectation at %0t", $time);
        end else chk("move", move, exp_q.pop_front());
      end else chk("no_pulse", move, 0);
      chk("mode", mode, m_st);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (follow && due) pos = apply(pos, m_mv);
    end
  endtask

  task automatic ticks(int n);
    int c = 0, g = 0;
    while (c < n && g < n * SD * 3 + 20) begin
      step();
      if (due) c++;
      g++;
    end
    tests++;
    if (c < n) begin
      fails++;
      $display("FAIL tick_timeout: got %0d ticks expected %0d", c, n);
    end
  endtask

  task automatic wait_until_cnt1();
    int g = 0;
    while (m_cnt != 1 && g < 20) begin step(); g++; end
  endtask

  initial begin
    int h, v;
    home = pk(400, 300); pos = pk(400, 300); ply = pk(150, 40);
    step(3);
    rst_n = 1; en = 1; follow = 1;
    ticks(320);
    wait_until_cnt1();
    en = 0; step(6); en = 1;
    ticks(3);
    follow = 0; pos = pk(400, 300); home = pk(400, 300); ply = pk(410, 270);
    ticks(3);
    ply = pk(420, 320); ticks(2);
    ply = pos; ticks(2);
    ply = pk(500, 300); ticks(2);
    pos = pk(430, 320); ply = pk(558, 320); ticks(2);
    ply = pk(150, 40); follow = 1; ticks(60);
    follow = 0; pos = pk(500, 31); ply = pk(500, 0); ticks(4);
    home = pk(783, 300); pos = pk(783, 300); ply = pk(150, 40); ticks(4);
    follow = 1; ticks(10);
    repeat (1500) begin
      h = pos[19:10]; v = pos[9:0];
      if ($urandom_range(0, 19) == 0)
        ply = pk(clamp(h + $urandom_range(0, 300) - 150), clamp(v + $urandom_range(0, 300) - 150));
      if ($urandom_range(0, 59) == 0) pos = pk($urandom_range(100, 830), $urandom_range(0, 550));
      if ($urandom_range(0, 99) == 0) home = pk($urandom_range(60, 900), $urandom_range(20, 520));
      en = $urandom_range(0, 15) != 0;
      step();
    end
    en = 1;
    begin
      int g = 0;
      while (!due && g < 20) begin step(); g++; end
    end
    rst_n = 0; step(2); rst_n = 1;
    ticks(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "timeout");
  end
endmodule
